// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2^AW x W register file with two asynchronous read
// ports, one enabled write port, a PC register at index DEPTH-1 reloaded
// from R15 every cycle, and a per-register pending-write scoreboard that
// lets a multi-cycle datapath stall reads of registers still in flight.
//
// Optional feature: define REGFILE_BYPASS_EN to forward WD3 straight to a
// read port (and force its rdy high) whenever that port reads the register
// being written in the same cycle.
module regfile_scoreboard #(
   parameter int W  = 32,
   parameter int AW = 4
) (
   input  logic          clock,
   input  logic          rst,
   input  logic [AW-1:0] A1,
   input  logic [AW-1:0] A2,
   input  logic [AW-1:0] A3,
   input  logic [W-1:0]  WD3,
   input  logic          enable,
   input  logic [W-1:0]  R15,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_addr,
   output logic [W-1:0]  RD1,
   output logic [W-1:0]  RD2,
   output logic          rdy1,
   output logic          rdy2,
   output logic [AW:0]   pend_cnt
);

   localparam int            DEPTH   = 1 << AW;
   localparam logic [AW-1:0] PC_ADDR = AW'(DEPTH - 1);

   logic [W-1:0]     regs_q [DEPTH];
   logic [W-1:0]     regs_d [DEPTH];
   logic [DEPTH-1:0] pending_q;
   logic [DEPTH-1:0] pending_d;
   logic [AW:0]      pend_cnt_q;
   logic [AW:0]      pend_cnt_d;

   // Next register contents: PC follows R15, an explicit write overrides it.
   always_comb begin
      regs_d = regs_q;
      regs_d[DEPTH-1] = R15;
      if (enable) begin
         regs_d[A3] = WD3;
      end
   end

   // Next scoreboard: a write retires its producer, a reserve issued in the
   // same cycle to the same register is a new producer and so wins. The PC
   // is rewritten every cycle and therefore can never be pending.
   always_comb begin
      pending_d = pending_q;
      if (enable) begin
         pending_d[A3] = 1'b0;
      end
      if (rsv_en && (rsv_addr != PC_ADDR)) begin
         pending_d[rsv_addr] = 1'b1;
      end
      pend_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_cnt_d = pend_cnt_d + (AW+1)'(pending_d[i]);
      end
   end

   // State registers; reset discards any write or reserve of the same cycle.
   always_ff @(posedge clock) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pending_q  <= '0;
         pend_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         pending_q  <= pending_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   // Combinational read ports and ready flags, with optional write-through.
   always_comb begin
      RD1  = regs_q[A1];
      RD2  = regs_q[A2];
      rdy1 = ~pending_q[A1];
      rdy2 = ~pending_q[A2];
`ifdef REGFILE_BYPASS_EN
      if (enable && (A1 == A3)) begin
         RD1  = WD3;
         rdy1 = 1'b1;
      end
      if (enable && (A2 == A3)) begin
         RD2  = WD3;
         rdy2 = 1'b1;
      end
`endif
   end

   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, reset-mid-operation
// sequence, randomized run against a reference model, and a short directed
// pass on a second instance with W=16, AW=3.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- main DUT (W=32, AW=4) ----------------
  logic        rst, enable, rsv_en;
  logic [3:0]  A1, A2, A3, rsv_addr;
  logic [31:0] WD3, R15, RD1, RD2;
  logic        rdy1, rdy2;
  logic [4:0]  pend_cnt;

  regfile_scoreboard #(.W(32), .AW(4)) dut (
    .clock(clock), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .enable(enable), .R15(R15), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .RD1(RD1), .RD2(RD2), .rdy1(rdy1), .rdy2(rdy2), .pend_cnt(pend_cnt)
  );

  // ---------------- small DUT (W=16, AW=3) ----------------
  logic        s_rst, s_en, s_rsv;
  logic [2:0]  s_A1, s_A2, s_A3, s_ra;
  logic [15:0] s_WD3, s_R15, s_RD1, s_RD2;
  logic        s_rdy1, s_rdy2;
  logic [3:0]  s_cnt;

  regfile_scoreboard #(.W(16), .AW(3)) dut_s (
    .clock(clock), .rst(s_rst), .A1(s_A1), .A2(s_A2), .A3(s_A3), .WD3(s_WD3),
    .enable(s_en), .R15(s_R15), .rsv_en(s_rsv), .rsv_addr(s_ra),
    .RD1(s_RD1), .RD2(s_RD2), .rdy1(s_rdy1), .rdy2(s_rdy2), .pend_cnt(s_cnt)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The register file is an array of values; "pending" is the set of
  // registers that have an issued but not yet retired producer.
  logic [31:0] m_regs [16];
  bit          m_pend [16];

  always @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] <= '0;
        m_pend[i] <= 1'b0;
      end
    end else begin
      m_regs[15] <= R15;
      if (enable) m_regs[A3] <= WD3;
      if (enable) m_pend[A3] <= 1'b0;
      if (rsv_en && rsv_addr != 4'd15) m_pend[rsv_addr] <= 1'b1;
    end
  end

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic check_model();
    logic [31:0] e1, e2;
    logic        y1, y2;
    e1 = m_regs[A1];
    e2 = m_regs[A2];
    y1 = ~m_pend[A1];
    y2 = ~m_pend[A2];
    if (BYP && enable && A1 == A3) begin e1 = WD3; y1 = 1'b1; end
    if (BYP && enable && A2 == A3) begin e2 = WD3; y2 = 1'b1; end
    chk("rnd_rd1", RD1, e1);
    chk("rnd_rd2", RD2, e2);
    chk("rnd_rdy1", rdy1, y1);
    chk("rnd_rdy2", rdy2, y2);
    chk("rnd_cnt", pend_cnt, m_count());
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic        en;
    logic [31:0] r15;
    logic        rsv;
    logic [3:0]  ra;
    logic        chk;
    logic [31:0] rd1, rd2;
    logic        rdy1, rdy2;
    logic [4:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] a1, logic [3:0] a2, logic [3:0] a3,
                              logic [31:0] wd3, logic en, logic [31:0] r15, logic rsv,
                              logic [3:0] ra, logic c, logic [31:0] rd1, logic [31:0] rd2,
                              logic y1, logic y2, logic [4:0] cnt);
    vec_t v;
    v.rst = r; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.wd3 = wd3; v.en = en; v.r15 = r15;
    v.rsv = rsv; v.ra = ra; v.chk = c; v.rd1 = rd1; v.rd2 = rd2; v.rdy1 = y1;
    v.rdy2 = y2; v.cnt = cnt;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] a3, input logic [31:0] wd3, input logic en,
                       input logic [31:0] r15, input logic rsv, input logic [3:0] ra);
    rst = r; A1 = a1; A2 = a2; A3 = a3; WD3 = wd3; enable = en; R15 = r15;
    rsv_en = rsv; rsv_addr = ra;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    s_rst = 1'b1; s_en = 1'b0; s_rsv = 1'b0; s_A1 = '0; s_A2 = '0; s_A3 = '0;
    s_ra = '0; s_WD3 = '0; s_R15 = '0;

    // reset and PC load
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0, 0, 32'h50, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 15, 1, 0, 0, 0, 0, 0, 0, 1, 32'h50, 0, 1, 1, 0));
    // write reg 3, read-during-write on port 2
    tbl.push_back(mk(0, 0, 3, 3, 32'hDEADBEEF, 1, 0, 0, 0, 1, 0,
                     BYP ? 32'hDEADBEEF : 32'h0, 1, 1, 0));
    tbl.push_back(mk(0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0));
    // reserve 5, then retire it with a write
    tbl.push_back(mk(0, 5, 3, 0, 0, 0, 0, 1, 5, 1, 0, 32'hDEADBEEF, 1, 1, 0));
    tbl.push_back(mk(0, 5, 0, 5, 32'h12, 1, 0, 0, 0, 1, BYP ? 32'h12 : 32'h0, 0,
                     BYP, 1, 1));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12, 0, 1, 1, 0));
    // reserve 7; then reserve and write 7 together: reserve wins
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 7, 0, 7, 32'h77, 1, 0, 1, 7, 1, BYP ? 32'h77 : 32'h0, 0,
                     BYP, 1, 1));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 1, 1));
    // reserve 2 while writing 7: independent, count stays 1
    tbl.push_back(mk(0, 2, 7, 7, 32'h78, 1, 0, 1, 2, 1, 0, BYP ? 32'h78 : 32'h77,
                     1, BYP, 1));
    tbl.push_back(mk(0, 2, 7, 0, 0, 0, 0, 0, 0, 1, 0, 32'h78, 0, 1, 1));
    // PC follows R15 with one cycle lag; branch write wins; PC reserve ignored
    tbl.push_back(mk(0, 15, 0, 0, 0, 0, 32'h100, 0, 0, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 15, 0, 0, 0, 0, 32'h104, 0, 0, 1, 32'h100, 0, 1, 1, 1));
    tbl.push_back(mk(0, 15, 0, 0, 0, 0, 32'h108, 0, 0, 1, 32'h104, 0, 1, 1, 1));
    tbl.push_back(mk(0, 15, 0, 15, 32'h200, 1, 32'h10C, 0, 0, 1,
                     BYP ? 32'h200 : 32'h108, 0, 1, 1, 1));
    tbl.push_back(mk(0, 15, 0, 0, 0, 0, 32'h110, 1, 15, 1, 32'h200, 0, 1, 1, 1));
    tbl.push_back(mk(0, 15, 2, 0, 0, 0, 0, 0, 0, 1, 32'h110, 0, 1, 0, 1));
    // retire reg 2
    tbl.push_back(mk(0, 2, 0, 2, 32'h22, 1, 0, 0, 0, 1, BYP ? 32'h22 : 32'h0, 0,
                     BYP, 1, 1));
    tbl.push_back(mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22, 0, 1, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].wd3, tbl[i].en,
            tbl[i].r15, tbl[i].rsv, tbl[i].ra);
      #2;
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d_rd1", i), RD1, tbl[i].rd1);
        chk($sformatf("vec%0d_rd2", i), RD2, tbl[i].rd2);
        chk($sformatf("vec%0d_rdy1", i), rdy1, tbl[i].rdy1);
        chk($sformatf("vec%0d_rdy2", i), rdy2, tbl[i].rdy2);
        chk($sformatf("vec%0d_cnt", i), pend_cnt, tbl[i].cnt);
      end
      step();
    end

    // reset in the middle of outstanding producers
    idle(); rsv_en = 1'b1; rsv_addr = 4'd1; step();
    rsv_addr = 4'd2; step();
    rsv_addr = 4'd3; step();
    idle(); A1 = 4'd1; A2 = 4'd3; #2;
    chk("mid_cnt3", pend_cnt, 5'd3);
    chk("mid_rdy1", rdy1, 1'b0);
    chk("mid_rdy2", rdy2, 1'b0);
    drive(1'b1, 4'd0, 4'd0, 4'd4, 32'h44, 1'b1, 32'h300, 1'b1, 4'd6);
    step();
    idle(); #2;
    chk("rst_cnt", pend_cnt, 5'd0);
    for (int a = 0; a < 16; a++) begin
      A1 = 4'(a); A2 = 4'(15 - a); #1;
      chk($sformatf("rst_rd1_%0d", a), RD1, 32'd0);
      chk($sformatf("rst_rd2_%0d", a), RD2, 32'd0);
      chk($sformatf("rst_rdy1_%0d", a), rdy1, 1'b1);
      chk($sformatf("rst_rdy2_%0d", a), rdy2, 1'b1);
    end
    step();

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      #2;
      check_model();
      step();
    end
    idle();

    // small configuration: W=16, AW=3, PC at index 7
    step();
    s_rst = 1'b0; s_R15 = 16'h0040; s_A1 = 3'd7; #2;
    chk("s_pc_reset", s_RD1, 16'h0);
    chk("s_cnt_reset", s_cnt, 4'd0);
    step();
    s_R15 = 16'h0; s_en = 1'b1; s_A3 = 3'd3; s_WD3 = 16'hBEEF; #2;
    chk("s_pc_load", s_RD1, 16'h0040);
    step();
    s_en = 1'b0; s_A1 = 3'd3; s_rsv = 1'b1; s_ra = 3'd5; #2;
    chk("s_write", s_RD1, 16'hBEEF);
    step();
    s_ra = 3'd7; s_A1 = 3'd5; #2;
    chk("s_rsv_rdy", s_rdy1, 1'b0);
    chk("s_rsv_cnt", s_cnt, 4'd1);
    step();
    s_rsv = 1'b0; s_A2 = 3'd7; #2;
    chk("s_pc_rdy", s_rdy2, 1'b1);
    chk("s_pc_cnt", s_cnt, 4'd1);
    s_en = 1'b1; s_A3 = 3'd5; s_WD3 = 16'h0012;
    step();
    s_en = 1'b0; s_rsv = 1'b1; s_ra = 3'd1; #2;
    chk("s_retire_rd", s_RD1, 16'h0012);
    chk("s_retire_rdy", s_rdy1, 1'b1);
    chk("s_retire_cnt", s_cnt, 4'd0);
    step();
    s_rst = 1'b1; s_ra = 3'd2;
    step();
    s_rst = 1'b0; s_rsv = 1'b0; s_A1 = 3'd1; #2;
    chk("s_rst_cnt", s_cnt, 4'd0);
    chk("s_rst_rdy", s_rdy1, 1'b1);
    chk("s_rst_rd", s_RD1, 16'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
